// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Brief    : Packs symbolic MIPS instructions into 32-bit words and streams
//            them to consecutive instruction-memory addresses.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 4096,
    parameter int          CNT_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [4:0]       in_mn,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             im_valid,
    input  logic             im_ready,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done,
    output logic             full,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [4:0] c_MN_NOP  = 5'd0;
    localparam logic [4:0] c_MN_ADD  = 5'd1;
    localparam logic [4:0] c_MN_SUB  = 5'd2;
    localparam logic [4:0] c_MN_ADDU = 5'd3;
    localparam logic [4:0] c_MN_SUBU = 5'd4;
    localparam logic [4:0] c_MN_AND  = 5'd5;
    localparam logic [4:0] c_MN_OR   = 5'd6;
    localparam logic [4:0] c_MN_SLT  = 5'd7;
    localparam logic [4:0] c_MN_JR   = 5'd8;
    localparam logic [4:0] c_MN_LW   = 5'd9;
    localparam logic [4:0] c_MN_SW   = 5'd10;
    localparam logic [4:0] c_MN_BEQ  = 5'd11;
    localparam logic [4:0] c_MN_ADDI = 5'd12;
    localparam logic [4:0] c_MN_ORI  = 5'd13;
    localparam logic [4:0] c_MN_LUI  = 5'd14;
    localparam logic [4:0] c_MN_J    = 5'd15;
    localparam logic [4:0] c_MN_JAL  = 5'd16;

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_im_valid;
    logic [31:0]       r_im_addr;
    logic [31:0]       r_im_wdata;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              r_full;

    logic [31:0]       w_enc;
    logic              w_legal;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain_ok;
    logic              w_enter_run;
    logic              w_hit_depth;
    logic [CNT_W-1:0]  w_count_inc;
    logic [31:0]       w_addr;

    // Unused fields of each format are forced to zero rather than passed through.
    always_comb begin
        w_enc   = 32'h0;
        w_legal = 1'b1;
        case (in_mn)
            c_MN_NOP:  w_enc = 32'h0;
            c_MN_ADD:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
            c_MN_SUB:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
            c_MN_ADDU: w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100001};
            c_MN_SUBU: w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100011};
            c_MN_AND:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
            c_MN_OR:   w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
            c_MN_SLT:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
            c_MN_JR:   w_enc = {6'b000000, in_rs, 15'b0, 6'b001000};
            c_MN_LW:   w_enc = {6'b100011, in_rs, in_rt, in_imm};
            c_MN_SW:   w_enc = {6'b101011, in_rs, in_rt, in_imm};
            c_MN_BEQ:  w_enc = {6'b000100, in_rs, in_rt, in_imm};
            c_MN_ADDI: w_enc = {6'b001000, in_rs, in_rt, in_imm};
            c_MN_ORI:  w_enc = {6'b001101, in_rs, in_rt, in_imm};
            c_MN_LUI:  w_enc = {6'b001111, 5'b0, in_rt, in_imm};
            c_MN_J:    w_enc = {6'b000010, in_target};
            c_MN_JAL:  w_enc = {6'b000011, in_target};
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_drain_ok  = !r_im_valid || im_ready;
    assign w_in_ready  = (r_state == S_RUN) && w_drain_ok;
    assign w_accept    = in_valid && w_in_ready;
    assign w_enter_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_count_inc = r_count + 1'b1;
    assign w_hit_depth = w_legal && (w_count_inc == c_DEPTH_CNT);
    assign w_addr      = BASE_ADDR + {{(30-CNT_W){1'b0}}, r_count, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && (in_last || w_hit_depth)) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_drain_ok) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A load and a drain on the same edge keep the register occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im_valid <= 1'b0;
            r_im_addr  <= 32'h0;
            r_im_wdata <= 32'h0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            if (w_enter_run) begin
                r_count <= '0;
                r_err   <= 1'b0;
                r_full  <= 1'b0;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_count <= w_count_inc;
                    if (w_hit_depth) begin
                        r_full <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_accept && w_legal) begin
                r_im_valid <= 1'b1;
                r_im_addr  <= w_addr;
                r_im_wdata <= w_enc;
            end else if (im_ready) begin
                r_im_valid <= 1'b0;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign im_valid = r_im_valid;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done     = (r_state == S_DONE);
    assign full     = r_full;
    assign err      = r_err;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_encoder
// Brief    : Directed-vector bench for the default and a DEPTH=4 encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_mn = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        im_ready = 1'b0;
    logic        sel = 1'b0;

    logic        a_in_ready, a_im_valid, a_busy, a_done, a_full, a_err;
    logic [31:0] a_im_addr, a_im_wdata;
    logic [12:0] a_count;
    logic        b_in_ready, b_im_valid, b_busy, b_done, b_full, b_err;
    logic [31:0] b_im_addr, b_im_wdata;
    logic [12:0] b_count;

    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mips_instr_encoder u_dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_last(in_last), .in_mn(in_mn), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .im_valid(a_im_valid), .im_ready(im_ready), .im_addr(a_im_addr),
        .im_wdata(a_im_wdata), .busy(a_busy), .done(a_done), .full(a_full),
        .err(a_err), .count(a_count)
    );

    mips_instr_encoder #(.DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_last(in_last), .in_mn(in_mn), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .im_valid(b_im_valid), .im_ready(im_ready), .im_addr(b_im_addr),
        .im_wdata(b_im_wdata), .busy(b_busy), .done(b_done), .full(b_full),
        .err(b_err), .count(b_count)
    );

    // Inputs only change at posedge+1, so a handshake seen here completes next edge.
    always @(negedge clk) begin
        if (a_im_valid && im_ready) begin
            qa_addr.push_back(a_im_addr);
            qa_data.push_back(a_im_wdata);
        end
        if (b_im_valid && im_ready) begin
            qb_addr.push_back(b_im_addr);
            qb_data.push_back(b_im_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa_d(input int i);
        return (i < qa_data.size()) ? qa_data[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qa_a(input int i);
        return (i < qa_addr.size()) ? qa_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_q();
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    endtask

    task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        bit ok;
        ok = 1'b0;
        in_mn = mn; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel ? b_in_ready : a_in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_data[10];
        logic [31:0] exp_r[6];
        int          rdy_seen;

        // reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_im_valid", 32'(a_im_valid), 32'd0);
        chk("rst_busy",     32'(a_busy),     32'd0);
        chk("rst_done",     32'(a_done),     32'd0);
        chk("rst_full",     32'(a_full),     32'd0);
        chk("rst_err",      32'(a_err),      32'd0);
        chk("rst_count",    32'(a_count),    32'd0);
        chk("rst_addr",     a_im_addr,       32'h0);
        chk("rst_wdata",    a_im_wdata,      32'h0);
        tick();

        // ten-word program, memory always ready
        im_ready = 1'b1;
        clear_q();
        pulse_start();
        chk("prog_busy", 32'(a_busy), 32'd1);
        send(5'd1,  5'd1,  5'd2, 5'd3,  16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd13, 5'd0,  5'd1, 5'd9,  16'h1234, 26'h3FFFFFF, 1'b0);
        send(5'd14, 5'd7,  5'd2, 5'd9,  16'hABCD, 26'h3FFFFFF, 1'b0);
        send(5'd9,  5'd29, 5'd4, 5'd0,  16'h0008, 26'h0,       1'b0);
        send(5'd10, 5'd0,  5'd5, 5'd0,  16'h0000, 26'h0,       1'b0);
        send(5'd11, 5'd1,  5'd2, 5'd0,  16'hFFFF, 26'h0,       1'b0);
        send(5'd15, 5'd3,  5'd3, 5'd3,  16'h5555, 26'h0000C03, 1'b0);
        send(5'd16, 5'd3,  5'd3, 5'd3,  16'h5555, 26'h0000C03, 1'b0);
        send(5'd8,  5'd31, 5'd7, 5'd7,  16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1);
        tick();
        exp_data = '{32'h00221820, 32'h34011234, 32'h3C02ABCD, 32'h8FA40008, 32'hAC050000,
                     32'h1022FFFF, 32'h08000C03, 32'h0C000C03, 32'h03E00008, 32'h00000000};
        chk("prog_done",   32'(a_done),   32'd1);
        chk("prog_busy_0", 32'(a_busy),   32'd0);
        chk("prog_count",  32'(a_count),  32'd10);
        chk("prog_writes", qa_data.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("prog_data%0d", i), qa_d(i), exp_data[i]);
            chk($sformatf("prog_addr%0d", i), qa_a(i), 32'h3000 + 32'(i * 4));
        end

        // restart from DONE, illegal mnemonic between two addi
        clear_q();
        pulse_start();
        chk("restart_count", 32'(a_count), 32'd0);
        chk("restart_done",  32'(a_done),  32'd0);
        send(5'd12, 5'd0, 5'd1, 5'd4, 16'h0005, 26'h0, 1'b0);
        send(5'd20, 5'd1, 5'd1, 5'd1, 16'h0001, 26'h0, 1'b0);
        chk("ill_err",   32'(a_err),   32'd1);
        chk("ill_count", 32'(a_count), 32'd1);
        send(5'd12, 5'd1, 5'd2, 5'd4, 16'hFFFE, 26'h0, 1'b1);
        tick();
        chk("ill_writes", qa_data.size(), 32'd2);
        chk("ill_addr0",  qa_a(0), 32'h3000);
        chk("ill_addr1",  qa_a(1), 32'h3004);
        chk("ill_data0",  qa_d(0), 32'h20010005);
        chk("ill_data1",  qa_d(1), 32'h2022FFFE);
        chk("ill_err_hold", 32'(a_err), 32'd1);
        chk("ill_done",   32'(a_done), 32'd1);

        // backpressure plus remaining R-type functs
        clear_q();
        pulse_start();
        chk("bp_err_clr", 32'(a_err), 32'd0);
        im_ready = 1'b0;
        send(5'd2, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_wdata",    a_im_wdata,      32'h00C72822);
            chk("bp_addr",     a_im_addr,       32'h3000);
            tick();
        end
        chk("bp_no_write", qa_data.size(), 32'd0);
        im_ready = 1'b1;
        tick();
        tick();
        chk("bp_one_write", qa_data.size(), 32'd1);
        send(5'd3, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd4, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd5, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd6, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(5'd7, 5'd6, 5'd7, 5'd5, 16'hFFFF, 26'h3FFFFFF, 1'b1);
        tick();
        exp_r = '{32'h00C72822, 32'h00C72821, 32'h00C72823,
                  32'h00C72824, 32'h00C72825, 32'h00C7282A};
        chk("rt_writes", qa_data.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rt_data%0d", i), qa_d(i), exp_r[i]);
        end
        chk("rt_addr5", qa_a(5), 32'h3014);

        // reset while a word is pending; start coincident with reset
        clear_q();
        pulse_start();
        im_ready = 1'b0;
        send(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("mrst_im_valid", 32'(a_im_valid), 32'd0);
        chk("mrst_addr",     a_im_addr,       32'h0);
        chk("mrst_wdata",    a_im_wdata,      32'h0);
        chk("mrst_busy",     32'(a_busy),     32'd0);
        chk("mrst_count",    32'(a_count),    32'd0);
        chk("mrst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        im_ready = 1'b1;
        tick();
        chk("mrst_no_write", qa_data.size(), 32'd0);
        pulse_start();
        send(5'd13, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 1'b1);
        tick();
        chk("mrst_reload_n",    qa_data.size(), 32'd1);
        chk("mrst_reload_addr", qa_a(0), 32'h3000);
        chk("mrst_reload_data", qa_d(0), 32'h34011234);

        // DEPTH=4 instance, six words offered
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_q();
        sel = 1'b1;
        pulse_start();
        send(5'd12, 5'd0, 5'd1, 5'd0, 16'h0001, 26'h0, 1'b0);
        send(5'd12, 5'd0, 5'd1, 5'd0, 16'h0002, 26'h0, 1'b0);
        send(5'd12, 5'd0, 5'd1, 5'd0, 16'h0003, 26'h0, 1'b0);
        send(5'd12, 5'd0, 5'd1, 5'd0, 16'h0004, 26'h0, 1'b0);
        in_valid = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_in_ready) rdy_seen++;
            tick();
        end
        in_valid = 1'b0;
        chk("dep_in_ready_seen", 32'(rdy_seen), 32'd0);
        chk("dep_writes",  qb_data.size(), 32'd4);
        chk("dep_last_addr", (qb_addr.size() == 4) ? qb_addr[3] : 32'hDEAD_BEEF, 32'h300C);
        chk("dep_last_data", (qb_data.size() == 4) ? qb_data[3] : 32'hDEAD_BEEF, 32'h20010004);
        chk("dep_full",  32'(b_full),  32'd1);
        chk("dep_done",  32'(b_done),  32'd1);
        chk("dep_count", 32'(b_count), 32'd4);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader for the P5 pipeline test harness: the inverse of the instruction decoder. It accepts one symbolic instruction per handshake (mnemonic code plus register and immediate fields), packs it into a 32-bit MIPS word, and writes it to consecutive instruction-memory byte addresses through a registered, back-pressured write port. It lets benches and boot logic build programs in hardware without an external hex file.

## Interface
- `BASE_ADDR`, 32'h0000_3000, byte address of the first written word.
- `DEPTH`, 4096, maximum number of words per program.
- `CNT_W`, 13, width of the word counter; must satisfy 2^CNT_W > DEPTH.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new program load.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  encoder accepts this cycle.
- `in_last`  in  1  accepted instruction is the final one.
- `in_mn`  in  5  mnemonic: 0 nop, 1 add, 2 sub, 3 addu, 4 subu, 5 and, 6 or, 7 slt, 8 jr, 9 lw, 10 sw, 11 beq, 12 addi, 13 ori, 14 lui, 15 j, 16 jal; 17–31 illegal.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  I-type immediate or offset, passed through unmodified.
- `in_target`  in  26  J-type word target.
- `im_valid`  out  1  write request to instruction memory.
- `im_ready`  in  1  memory takes the word this cycle.
- `im_addr`  out  32  byte address, word-aligned.
- `im_wdata`  out  32  encoded instruction.
- `busy`, `done`, `full`, `err`  out  1 each  status flags.
- `count`  out  CNT_W  words emitted in the current program.

## Operation
- Encoding:
  - R-type: {6'b0, rs, rt, rd, 5'b0, funct}. Funct values: add 100000, sub 100010, addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - jr: {6'b0, rs, 15'b0, 6'b001000}.
  - nop: 32'h0.
  - I-type: {op, rs, rt, imm}. Opcodes: lw 100011, sw 101011, beq 000100, addi 001000, ori 001101.
  - lui: {6'b001111, 5'b0, rt, imm}; `in_rs` is ignored.
  - j and jal: {op, target} with opcodes 000010 and 000011.
  - Fields a mnemonic does not use are forced to zero.
- FSM states:
  - IDLE (reset state) → RUN on `start`.
  - RUN → FLUSH when an accepted instruction has `in_last`=1, or when the accept raises `count` to DEPTH.
  - FLUSH → DONE once the output register is empty, including the cycle it drains.
  - DONE → RUN on `start`.
  - `start` is ignored in RUN and FLUSH.
- Entering RUN clears `count`, `err`, `full`.
- `in_ready` = (state==RUN) && (!im_valid || im_ready).
- Accept = `in_valid` && `in_ready`.
  - Legal mnemonic: load output register with `im_addr` = BASE_ADDR + {count, 2'b00}, then `count`+1.
  - Illegal mnemonic: set `err` (sticky until next `start`/`reset`); no write and `count` unchanged. `in_last` is still honored.
- `full` is set when `count` reaches DEPTH and holds until the next `start`.
- `busy` = RUN or FLUSH. `done` = DONE.
- Address arithmetic is modulo 2^32 with no carry checks.

## Timing
- Reset values: state IDLE; `in_ready`, `im_valid`, `busy`, `done`, `full`, `err` = 0; `count` = 0; `im_addr`, `im_wdata` = 0.
- Latency: an instruction accepted at edge N drives `im_valid`/`im_addr`/`im_wdata` from edge N until the edge where `im_ready`=1 is sampled.
- Output payload is stable while `im_valid`=1 and `im_ready`=0.
- Throughput: 1 word/cycle when `im_ready` is held high. The drain and a new load complete on the same edge.
- `start` coincident with `reset`: reset wins.
- `reset` mid-load: the pending output word is dropped and not written.
- Boundaries:
  - `in_last` on the DEPTH-th word: single transition to FLUSH, `full`=1.
  - An illegal mnemonic with `in_last`: FLUSH with `count` unchanged.

## Test plan
- Ten-word program, `im_ready`=1:
  - add $3,$1,$2 → 0x00221820 @0x3000
  - ori $1,$0,0x1234 → 0x34011234 @0x3004
  - lui $2,0xABCD → 0x3C02ABCD
  - lw $4,8($29) → 0x8FA40008
  - sw $5,0($0) → 0xAC050000
  - beq $1,$2,-1 → 0x1022FFFF
  - j 0xC03 → 0x08000C03
  - jal 0xC03 → 0x0C000C03
  - jr $31 → 0x03E00008
  - nop with `in_last` → 0x0; then `done`=1, `count`=10.
- Backpressure: hold `im_ready`=0 for 5 cycles after the first accept. Required: `in_ready`=0 throughout, payload unchanged, exactly one write when `im_ready` rises.
- Illegal mnemonic 20 between two addi instructions. Required: `err`=1, only 2 writes, at 0x3000 and 0x3004.
- DEPTH=4 instance, 6 offered words. Required: 4 writes ending at 0x300C, `full`=1, `in_ready` stays 0, `done`=1.
- `reset` asserted with `im_valid`=1 and `im_ready`=0. Required: next cycle all outputs at reset values and no write. A following `start` reloads from 0x3000.
- `start` in DONE. Required: `count`/`err`/`full` cleared, first write at 0x3000.
